// File: rtl/axi_pkg.sv
// Shared AXI encodings, the read-master FSM state type and the arsize helper.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } rd_state_e;

  function automatic logic [2:0] calc_arsize(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_rd_master_fifo.sv
// Synchronous FIFO with flop storage; the output word is read straight from a register.
module axi_rd_master_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_rd_master.sv
// AXI4 single-outstanding read initiator; response checking enabled by AXI_RD_MASTER_RESP_CHK_EN.
// state   | meaning
// ST_IDLE | ready for a command
// ST_ADDR | AR presented, waiting for arready
// ST_DATA | collecting beats until the counter reaches len
module axi_rd_master
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [ID_WIDTH-1:0]   arid,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [ID_WIDTH-1:0]   rid,
  output logic                  dat_vld,
  input  logic                  dat_rdy,
  output logic [DATA_WIDTH-1:0] dat,
  output logic                  dat_last,
  output logic                  err,
  output logic                  busy
);

  localparam logic [2:0] ARSIZE = calc_arsize(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'((1 << ARSIZE) - 1));

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  logic              cmd_acc, beat, beat_last;
  logic              fifo_full, fifo_empty;
  logic [DATA_WIDTH:0] fifo_dout;

  assign cmd_rdy   = (state_q == ST_IDLE);
  assign arvalid   = (state_q == ST_ADDR);
  assign rready    = (state_q == ST_DATA) && !fifo_full;
  assign busy      = (state_q != ST_IDLE);
  assign araddr    = addr_q;
  assign arlen     = len_q;
  assign arid      = id_q;
  assign arsize    = ARSIZE;
  assign arburst   = BURST_INCR;
  assign cmd_acc   = cmd_vld && cmd_rdy;
  assign beat      = rvalid && rready;
  assign beat_last = (cnt_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          addr_d  = cmd_addr & ALIGN_MASK;
          len_d   = cmd_len;
          id_d    = cmd_id;
          cnt_d   = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        // Termination comes from the beat counter alone; rlast is only cross-checked.
        if (beat) begin
          cnt_d = cnt_q + 8'd1;
          if (beat_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  axi_rd_master_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (beat),
    .din_i   ({beat_last, rdata}),
    .pop_i   (dat_rdy),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dat_vld  = !fifo_empty;
  assign dat      = fifo_dout[DATA_WIDTH-1:0];
  assign dat_last = fifo_dout[DATA_WIDTH];

`ifdef AXI_RD_MASTER_RESP_CHK_EN
  logic err_q, err_d, beat_bad;

  assign beat_bad = (rresp == RESP_SLVERR) || (rresp == RESP_DECERR) ||
                    (rlast != beat_last) || (rid != id_q);

  always_comb begin
    err_d = err_q;
    if (cmd_acc)               err_d = 1'b0;
    else if (beat && beat_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast, rid, cmd_acc};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master: reset, basic burst, backpressure, AR stall, response errors, reset mid-burst.
module tb_axi_rd_master;
  localparam int DW = 64;

`ifdef AXI_RD_MASTER_RESP_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk, rst;
  logic          cmd_vld, cmd_rdy;
  logic [7:0]    cmd_addr, cmd_len;
  logic [3:0]    cmd_id;
  logic          arvalid, arready;
  logic [7:0]    araddr, arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [3:0]    arid;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic [3:0]    rid;
  logic          dat_vld, dat_rdy;
  logic [DW-1:0] dat;
  logic          dat_last, err, busy;

  int errors = 0;
  int checks = 0;
  logic [DW:0] mon_q[$];

  axi_rd_master dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .dat_vld(dat_vld), .dat_rdy(dat_rdy), .dat(dat), .dat_last(dat_last), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && dat_vld && dat_rdy) mon_q.push_back({dat_last, dat});

  task automatic issue_cmd(input logic [7:0] a, input logic [7:0] l, input logic [3:0] id);
    int g = 0;
    cmd_addr = a; cmd_len = l; cmd_id = id; cmd_vld = 1'b1;
    while (!cmd_rdy && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    checks++;
    if (g >= 50) begin errors++; $display("FAIL cmd_accept_timeout: cmd_rdy=%b required 1", cmd_rdy); end
  endtask

  // Beat indices are relative to this call; -1 disables the error/rlast injection.
  task automatic send_beats(input int n, input logic [DW-1:0] base, input int err_beat,
                            input int last_beat, input logic [3:0] id);
    int i = 0;
    int g = 0;
    logic hs;
    while (i < n && g < 300) begin
      rvalid = 1'b1;
      rdata  = base + DW'(i);
      rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      rlast  = (i == last_beat);
      rid    = id;
      hs     = rready;
      @(posedge clk); #1;
      g++;
      if (hs) i++;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    checks++;
    if (i != n) begin errors++; $display("FAIL beats_timeout: accepted=%0d required %0d", i, n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_vld = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0; arready = 1'b1;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0; dat_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_rdy, busy, err, rready} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: got %b required 1000", {cmd_rdy, busy, err, rready});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b0, 8'h00, 8'h00, 3'd3, 2'b01, 4'h0}) begin
      errors++; $display("FAIL reset_ar: got %h required %h", {arvalid, araddr, arlen, arsize, arburst, arid},
                         {1'b0, 8'h00, 8'h00, 3'd3, 2'b01, 4'h0});
    end
    checks++;
    if ({dat_vld, dat_last, dat} !== {2'b00, 64'h0}) begin
      errors++; $display("FAIL reset_dat: got %h required 0", {dat_vld, dat_last, dat});
    end
  endtask

  task automatic test_basic();
    logic [DW:0] exp;
    mon_q.delete();
    cmd_addr = 8'h13; cmd_len = 8'd3; cmd_id = 4'h5; cmd_vld = 1'b1;
    checks++;
    if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL basic_cmd_rdy: got %b required 1", cmd_rdy); end
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    checks++;
    if ({arvalid, araddr, arlen, arsize, arburst, arid, cmd_rdy, busy} !==
        {1'b1, 8'h10, 8'h03, 3'd3, 2'b01, 4'h5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL basic_ar: got %h required %h", {arvalid, araddr, arlen, arsize, arburst, arid, cmd_rdy, busy},
                         {1'b1, 8'h10, 8'h03, 3'd3, 2'b01, 4'h5, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    checks++;
    if ({arvalid, rready, dat_vld} !== 3'b010) begin
      errors++; $display("FAIL basic_data_entry: got %b required 010", {arvalid, rready, dat_vld});
    end
    send_beats(4, 64'hDEAD_0000_0000_00A0, -1, 3, 4'h5);
    checks++;
    if ({cmd_rdy, busy, rready} !== 3'b100) begin
      errors++; $display("FAIL basic_idle_after_last: got %b required 100", {cmd_rdy, busy, rready});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mon_q.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d required 4", mon_q.size()); end
    for (int k = 0; k < 4 && k < mon_q.size(); k++) begin
      exp = {1'(k == 3), 64'hDEAD_0000_0000_00A0 + DW'(k)};
      checks++;
      if (mon_q[k] !== exp) begin errors++; $display("FAIL basic_word%0d: got %h required %h", k, mon_q[k], exp); end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b required 0", err); end
  endtask

  task automatic test_backpressure();
    logic [DW:0] exp;
    mon_q.delete();
    dat_rdy = 1'b0;
    issue_cmd(8'h40, 8'd7, 4'h2);
    fork
      send_beats(8, 64'h0000_BEEF_0000_B000, -1, 7, 4'h2);
      begin
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({rready, dat_vld} !== 2'b01) begin
          errors++; $display("FAIL bp_full_stall: got rready,dat_vld=%b required 01", {rready, dat_vld});
        end
        dat_rdy = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({mon_q.size() == 8, busy} !== 2'b10) begin
      errors++; $display("FAIL bp_count: got %0d words busy=%b required 8 words busy=0", mon_q.size(), busy);
    end
    for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
      exp = {1'(k == 7), 64'h0000_BEEF_0000_B000 + DW'(k)};
      checks++;
      if (mon_q[k] !== exp) begin errors++; $display("FAIL bp_word%0d: got %h required %h", k, mon_q[k], exp); end
    end
  endtask

  task automatic test_ar_stall();
    mon_q.delete();
    arready = 1'b0;
    issue_cmd(8'h2F, 8'd0, 4'h9);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({arvalid, araddr, arlen, arid, cmd_rdy, rready} !== {1'b1, 8'h28, 8'h00, 4'h9, 1'b0, 1'b0}) begin
        errors++; $display("FAIL ar_stall_c%0d: got %h required %h", k, {arvalid, araddr, arlen, arid, cmd_rdy, rready},
                           {1'b1, 8'h28, 8'h00, 4'h9, 1'b0, 1'b0});
      end
      @(posedge clk); #1;
    end
    arready = 1'b1;
    send_beats(1, 64'h0C0, -1, 0, 4'h9);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mon_q.size() != 1 || mon_q[0] !== {1'b1, 64'h0C0} || busy !== 1'b0) begin
      errors++; $display("FAIL ar_stall_data: got %0d words first=%h busy=%b required 1 word %h busy=0",
                         mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 65'h0, busy, {1'b1, 64'h0C0});
    end
  endtask

  task automatic test_resp_err();
    issue_cmd(8'h08, 8'd3, 4'h1);
    send_beats(2, 64'h0D0, -1, -1, 4'h1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL resp_err_early: got %b required 0", err); end
    send_beats(2, 64'h0D2, 0, 1, 4'h1);
    checks++;
    if (err !== EXP_ERR) begin errors++; $display("FAIL resp_err_set: got %b required %b", err, EXP_ERR); end
    issue_cmd(8'h08, 8'd0, 4'h1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL resp_err_clear: got %b required 0", err); end
    send_beats(1, 64'h0D8, -1, 0, 4'h1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL resp_err_clean: got %b required 0", err); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_rlast_mismatch();
    mon_q.delete();
    issue_cmd(8'h10, 8'd1, 4'h3);
    send_beats(1, 64'h0E0, -1, 0, 4'h3);
    checks++;
    if ({busy, rready, err} !== {2'b11, EXP_ERR}) begin
      errors++; $display("FAIL rlast_early: got %b required %b", {busy, rready, err}, {2'b11, EXP_ERR});
    end
    send_beats(1, 64'h0E1, -1, -1, 4'h3);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, err} !== {1'b0, EXP_ERR} || mon_q.size() != 2) begin
      errors++; $display("FAIL rlast_end: got busy,err=%b words=%0d required %b words=2", {busy, err}, mon_q.size(), {1'b0, EXP_ERR});
    end
    checks++;
    if (mon_q.size() == 2 && {mon_q[0], mon_q[1]} !== {1'b0, 64'h0E0, 1'b1, 64'h0E1}) begin
      errors++; $display("FAIL rlast_words: got %h %h required %h %h", mon_q[0], mon_q[1], {1'b0, 64'h0E0}, {1'b1, 64'h0E1});
    end
  endtask

  task automatic test_reset_mid();
    mon_q.delete();
    dat_rdy = 1'b0;
    issue_cmd(8'h20, 8'd4, 4'h6);
    send_beats(2, 64'h0F0, -1, 4, 4'h6);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_rdy, arvalid, rready, dat_vld, dat_last, err, busy} !== 7'b1000000) begin
      errors++; $display("FAIL rst_mid_ctrl: got %b required 1000000", {cmd_rdy, arvalid, rready, dat_vld, dat_last, err, busy});
    end
    checks++;
    if ({araddr, arlen, arid, dat} !== '0) begin
      errors++; $display("FAIL rst_mid_data: got %h required 0", {araddr, arlen, arid, dat});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    dat_rdy = 1'b1;
    issue_cmd(8'h30, 8'd1, 4'h7);
    send_beats(2, 64'h1234, -1, 1, 4'h7);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mon_q.size() != 2 || {mon_q[0], mon_q[1]} !== {1'b0, 64'h1234, 1'b1, 64'h1235}) begin
      errors++; $display("FAIL rst_mid_recover: got %0d words required 2 words 1234/1235", mon_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [DW:0] exp;
    mon_q.delete();
    dat_rdy = 1'b0;
    issue_cmd(8'h00, 8'd1, 4'h4);
    send_beats(2, 64'h050, -1, 1, 4'h4);
    checks++;
    if ({cmd_rdy, dat_vld} !== 2'b11) begin
      errors++; $display("FAIL b2b_ready_with_data: got %b required 11", {cmd_rdy, dat_vld});
    end
    issue_cmd(8'h08, 8'd1, 4'h4);
    send_beats(2, 64'h052, -1, 1, 4'h4);
    dat_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (mon_q.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d required 4", mon_q.size()); end
    for (int k = 0; k < 4 && k < mon_q.size(); k++) begin
      exp = {1'(k == 1 || k == 3), 64'h050 + DW'(k)};
      checks++;
      if (mon_q[k] !== exp) begin errors++; $display("FAIL b2b_word%0d: got %h required %h", k, mon_q[k], exp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ar_stall();
    test_resp_err();
    test_rlast_mismatch();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
